// File: rtl/servo_slew_ramp.sv
// rtl/servo_slew_ramp.sv - frame-synchronous servo position slew-rate limiter
module servo_slew_ramp #(
    parameter int C_CLK_FREQ_HZ   = 100000000,
    parameter int C_PERIOD_US     = 20000,
    parameter int C_POS_WIDTH     = 8,
    parameter int C_POS_INIT      = 128,
    parameter int C_SETTLE_FRAMES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [C_POS_WIDTH-1:0] target,
    input  logic                   target_valid,
    output logic                   target_ready,
    input  logic [C_POS_WIDTH-1:0] step,
    output logic [C_POS_WIDTH-1:0] position,
    output logic                   moving,
    output logic                   frame_tick,
    output logic                   done
);

    localparam int FRAME_CYCLES = (C_CLK_FREQ_HZ / 1000000) * C_PERIOD_US;
    localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int SW = $clog2(C_SETTLE_FRAMES + 1);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(C_SETTLE_FRAMES - 1);
    localparam logic [C_POS_WIDTH-1:0] POS_INIT = C_POS_WIDTH'(C_POS_INIT);

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        SETTLE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]          frame_cnt, frame_cnt_next;
    logic [SW-1:0]          settle_cnt, settle_next;
    logic [C_POS_WIDTH-1:0] target_reg, target_next;
    logic [C_POS_WIDTH-1:0] pos_next;
    logic                   done_next;
    logic                   accept;
    logic signed [C_POS_WIDTH:0] diff;
    logic [C_POS_WIDTH:0]   mag;

    assign frame_cnt_next = (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + CW'(1);
    assign accept = target_valid & target_ready;
    assign diff   = $signed({1'b0, target_reg}) - $signed({1'b0, position});
    assign mag    = diff[C_POS_WIDTH] ? C_POS_WIDTH'(0) - diff : diff;

    // Free-running frame counter; frame_tick is registered so it is high while the count sits at its last value
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt  <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_cnt  <= frame_cnt_next;
            frame_tick <= (frame_cnt_next == FRAME_LAST);
        end
    end

    // Next-state and datapath decisions; position only moves on a frame tick so the PWM pulse never changes mid-period
    always_comb begin
        state_next  = state;
        pos_next    = position;
        settle_next = settle_cnt;
        done_next   = 1'b0;
        target_next = accept ? target : target_reg;
        case (state)
            IDLE: begin
                if (accept) state_next = RAMP;
            end
            RAMP: begin
                // A target accepted on this same tick only takes effect from the following tick
                if (frame_tick && enable) begin
                    if (step == '0 || mag <= {1'b0, step}) begin
                        pos_next    = target_reg;
                        settle_next = '0;
                        state_next  = SETTLE;
                    end else if (diff[C_POS_WIDTH]) begin
                        pos_next = position - step;
                    end else begin
                        pos_next = position + step;
                    end
                end
            end
            SETTLE: begin
                if (frame_tick) begin
                    settle_next = settle_cnt + SW'(1);
                    if (settle_cnt == SETTLE_LAST) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers; ready and moving come from the next state so they line up with the state itself
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            position     <= POS_INIT;
            target_reg   <= POS_INIT;
            settle_cnt   <= '0;
            done         <= 1'b0;
            moving       <= 1'b0;
            target_ready <= 1'b0;
        end else begin
            state        <= state_next;
            position     <= pos_next;
            target_reg   <= target_next;
            settle_cnt   <= settle_next;
            done         <= done_next;
            moving       <= (state_next != IDLE);
            target_ready <= (state_next != SETTLE);
        end
    end

endmodule
